// File: rtl/spi_to_nitta_joiner_if.sv
// Bus between an SPI receiver and the NITTA word joiner.
//   spi_ready      : level, high while a completed subframe is held on from_spi
//   from_spi       : received subframe (SPI_DATA_WIDTH bits)
//   frame_end      : single-cycle strobe at the end of an SPI transaction
//   err_clr        : clears the sticky partial_error flag
//   to_nitta       : last completely assembled word (DATA_WIDTH bits)
//   joiner_ready   : one-cycle pulse, to_nitta holds a new word
//   partial_error  : sticky, a frame ended with an incomplete word
//   words_received : completed word count, modulo 256
// master: the SPI/host side driving the bus; slave: the joiner.
interface spi_to_nitta_joiner_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8
);
    logic                      spi_ready;
    logic [SPI_DATA_WIDTH-1:0] from_spi;
    logic                      frame_end;
    logic                      err_clr;
    logic [DATA_WIDTH-1:0]     to_nitta;
    logic                      joiner_ready;
    logic                      partial_error;
    logic [7:0]                words_received;

    modport master (
        output spi_ready, from_spi, frame_end, err_clr,
        input  to_nitta, joiner_ready, partial_error, words_received
    );

    modport slave (
        input  spi_ready, from_spi, frame_end, err_clr,
        output to_nitta, joiner_ready, partial_error, words_received
    );
endinterface

// File: rtl/spi_to_nitta_joiner.sv
// Assembles SPI subframes (MSB first) into DATA_WIDTH-bit NITTA words.
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : spi_to_nitta_joiner_if.slave (SPI inputs, assembled word, status)
// One capture per high period of spi_ready (ARMED/HELD handshake). A frame_end
// with an incomplete word discards it and sets the sticky partial_error.
module spi_to_nitta_joiner #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_to_nitta_joiner_if.slave     bus
);
    localparam int SUBFRAME_NUMBER = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int CNT_W           = $clog2(SUBFRAME_NUMBER);
    localparam logic [CNT_W-1:0] LAST_SUBFRAME = CNT_W'(SUBFRAME_NUMBER - 1);

    typedef enum logic {ARMED, HELD} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   to_nitta_q, to_nitta_d;
    logic                    ready_q, ready_d;
    logic                    perr_q, perr_d;
    logic [7:0]              words_q, words_d;
    logic                    capture;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        to_nitta_d = to_nitta_q;
        ready_d    = 1'b0;
        words_d    = words_q;
        perr_d     = perr_q & ~bus.err_clr;
        capture    = 1'b0;

        case (state_q)
            ARMED: if (bus.spi_ready) begin
                capture = 1'b1;
                state_d = HELD;
            end
            HELD: if (!bus.spi_ready) state_d = ARMED;
            default: state_d = ARMED;
        endcase

        if (capture) begin
            shift_d = {shift_q[DATA_WIDTH-SPI_DATA_WIDTH-1:0], bus.from_spi};
            if (cnt_q == LAST_SUBFRAME) begin
                to_nitta_d = shift_d;
                cnt_d      = '0;
                ready_d    = 1'b1;
                words_d    = words_q + 8'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Evaluated after the capture so a completing capture in the same
        // cycle delivers its word instead of flagging an error.
        if (bus.frame_end && (cnt_d != '0)) begin
            cnt_d   = '0;
            shift_d = '0;
            perr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A subframe already on the bus at reset must not be captured.
            state_q    <= bus.spi_ready ? HELD : ARMED;
            cnt_q      <= '0;
            shift_q    <= '0;
            to_nitta_q <= '0;
            ready_q    <= 1'b0;
            perr_q     <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            to_nitta_q <= to_nitta_d;
            ready_q    <= ready_d;
            perr_q     <= perr_d;
            words_q    <= words_d;
        end
    end

    assign bus.to_nitta       = to_nitta_q;
    assign bus.joiner_ready   = ready_q;
    assign bus.partial_error  = perr_q;
    assign bus.words_received = words_q;
endmodule

// File: tb/tb_spi_to_nitta_joiner.sv
module tb_spi_to_nitta_joiner;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   pulse_base;
    logic rdy_after, rdy_late;
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    spi_to_nitta_joiner_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) bus ();

    spi_to_nitta_joiner #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (!rst && bus.joiner_ready === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One spi_ready pulse of one cycle; rdy_a = joiner_ready the cycle after
    // the capture edge, rdy_l = joiner_ready one cycle later.
    task automatic send(input logic [7:0] b, output logic rdy_a, output logic rdy_l);
        @(negedge clk);
        bus.from_spi  = b;
        bus.spi_ready = 1'b1;
        @(negedge clk);
        rdy_a = bus.joiner_ready;
        bus.spi_ready = 1'b0;
        @(negedge clk);
        rdy_l = bus.joiner_ready;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.spi_ready = 1'b0;
        bus.from_spi  = '0;
        bus.frame_end = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_to_nitta", bus.to_nitta, 32'h0);
        check("rst_ready", {31'd0, bus.joiner_ready}, 32'd0);
        check("rst_perr", {31'd0, bus.partial_error}, 32'd0);
        check("rst_words", {24'd0, bus.words_received}, 32'd0);
        rst = 1'b0;

        // Basic word DEADBEEF
        send(8'hDE, rdy_after, rdy_late);
        send(8'hAD, rdy_after, rdy_late);
        check("partial_no_ready", {31'd0, rdy_after}, 32'd0);
        check("partial_keeps_to_nitta", bus.to_nitta, 32'h0);
        send(8'hBE, rdy_after, rdy_late);
        send(8'hEF, rdy_after, rdy_late);
        check("deadbeef_ready", {31'd0, rdy_after}, 32'd1);
        check("deadbeef_ready_1cyc", {31'd0, rdy_late}, 32'd0);
        check("deadbeef_word", bus.to_nitta, 32'hDEADBEEF);
        check("deadbeef_words", {24'd0, bus.words_received}, 32'd1);

        // spi_ready held high 10 cycles -> exactly one capture
        pulse_base = pulse_cnt;
        @(negedge clk);
        bus.from_spi  = 8'h11;
        bus.spi_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.spi_ready = 1'b0;
        check("held_no_ready", pulse_cnt - pulse_base, 32'd0);
        send(8'h22, rdy_after, rdy_late);
        send(8'h33, rdy_after, rdy_late);
        send(8'h44, rdy_after, rdy_late);
        check("held_one_capture", bus.to_nitta, 32'h11223344);
        check("held_words", {24'd0, bus.words_received}, 32'd2);

        // frame_end mid-word
        send(8'h01, rdy_after, rdy_late);
        send(8'h02, rdy_after, rdy_late);
        @(negedge clk); bus.frame_end = 1'b1;
        @(negedge clk); bus.frame_end = 1'b0;
        check("fe_perr_set", {31'd0, bus.partial_error}, 32'd1);
        check("fe_to_nitta_kept", bus.to_nitta, 32'h11223344);
        send(8'hCA, rdy_after, rdy_late);
        send(8'hFE, rdy_after, rdy_late);
        send(8'hBA, rdy_after, rdy_late);
        send(8'hBE, rdy_after, rdy_late);
        check("cafebabe_word", bus.to_nitta, 32'hCAFEBABE);
        check("cafebabe_words", {24'd0, bus.words_received}, 32'd3);
        check("perr_sticky", {31'd0, bus.partial_error}, 32'd1);
        @(negedge clk); bus.err_clr = 1'b1;
        @(negedge clk); bus.err_clr = 1'b0;
        check("err_clr", {31'd0, bus.partial_error}, 32'd0);

        // set wins over same-cycle err_clr
        send(8'h05, rdy_after, rdy_late);
        @(negedge clk); bus.frame_end = 1'b1; bus.err_clr = 1'b1;
        @(negedge clk); bus.frame_end = 1'b0; bus.err_clr = 1'b0;
        check("set_wins_clr", {31'd0, bus.partial_error}, 32'd1);
        @(negedge clk); bus.err_clr = 1'b1;
        @(negedge clk); bus.err_clr = 1'b0;

        // frame_end with counter 0 and no capture: no effect
        @(negedge clk); bus.frame_end = 1'b1;
        @(negedge clk); bus.frame_end = 1'b0;
        check("fe_idle_no_err", {31'd0, bus.partial_error}, 32'd0);

        // frame_end coincident with a non-completing first capture
        @(negedge clk); bus.from_spi = 8'h77; bus.spi_ready = 1'b1; bus.frame_end = 1'b1;
        @(negedge clk); bus.spi_ready = 1'b0; bus.frame_end = 1'b0;
        check("fe_first_capture_err", {31'd0, bus.partial_error}, 32'd1);
        @(negedge clk); bus.err_clr = 1'b1;
        @(negedge clk); bus.err_clr = 1'b0;

        // frame_end coincident with the completing capture
        send(8'h12, rdy_after, rdy_late);
        send(8'h34, rdy_after, rdy_late);
        send(8'h56, rdy_after, rdy_late);
        @(negedge clk); bus.from_spi = 8'h78; bus.spi_ready = 1'b1; bus.frame_end = 1'b1;
        @(negedge clk);
        check("fe_complete_ready", {31'd0, bus.joiner_ready}, 32'd1);
        bus.spi_ready = 1'b0; bus.frame_end = 1'b0;
        @(negedge clk);
        check("fe_complete_word", bus.to_nitta, 32'h12345678);
        check("fe_complete_no_err", {31'd0, bus.partial_error}, 32'd0);
        check("fe_complete_words", {24'd0, bus.words_received}, 32'd4);

        // Reset mid-word with spi_ready high through release
        send(8'hAA, rdy_after, rdy_late);
        @(negedge clk); rst = 1'b1; bus.spi_ready = 1'b1; bus.from_spi = 8'h99;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_words", {24'd0, bus.words_received}, 32'd0);
        check("rstmid_perr", {31'd0, bus.partial_error}, 32'd0);
        check("rstmid_to_nitta", bus.to_nitta, 32'h0);
        bus.spi_ready = 1'b0;
        @(negedge clk);
        send(8'h01, rdy_after, rdy_late);
        send(8'h02, rdy_after, rdy_late);
        send(8'h03, rdy_after, rdy_late);
        send(8'h04, rdy_after, rdy_late);
        check("rstmid_clean_word", bus.to_nitta, 32'h01020304);
        check("rstmid_clean_words", {24'd0, bus.words_received}, 32'd1);

        // 256 words: counter wraps through 0 back to 1
        pulse_base = pulse_cnt;
        for (int w = 0; w < 256; w++) begin
            for (int k = 0; k < 4; k++) begin
                send(8'(w + k), rdy_after, rdy_late);
            end
            if (w == 254) check("wrap_to_zero", {24'd0, bus.words_received}, 32'd0);
        end
        exp_word = {8'd255, 8'd0, 8'd1, 8'd2};
        check("wrap_last_word", bus.to_nitta, exp_word);
        check("wrap_words", {24'd0, bus.words_received}, 32'd1);
        check("wrap_pulses", pulse_cnt - pulse_base, 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
